bg_line_prefetcher: RTL and testbench
=====================================

Name: bg_line_prefetcher

Overview:
- Schedules reads of the background pixel ROM so each visible scanline's palette indices are ready before the scan reaches it.
- During horizontal blanking it copies the next line's 80 ROM words into the idle half of a ping-pong line buffer.
- Shares the single ROM port with one auxiliary requester (sprite/foreground logic), giving the background fetch priority.
- Feeds the palette ROM lookup stage with one palette index per pixel.

Parameters:
- H_VISIBLE, 640, visible pixels per line.
- V_VISIBLE, 480, visible lines per frame.
- V_TOTAL, 525, total lines per frame, blanking included.
- WORDS_PER_LINE, 80, ROM words per line; one word covers 8 horizontal pixels.
- ROM_LAT, 1, ROM read latency in cycles (synchronous ROM).
- ADDR_W, 16, ROM address width.
- DATA_W, 8, palette index width.

Ports:
- Clk  in  1  system clock, 50 MHz; DrawX advances every second cycle.
- Reset  in  1  asynchronous, active-high.
- DrawX  in  10  current scan column, 0..799.
- DrawY  in  10  current scan line, 0..524.
- rom_addr  out  ADDR_W  pixel ROM address.
- rom_data  in  DATA_W  pixel ROM data, valid ROM_LAT cycles after rom_addr.
- aux_req  in  1  auxiliary read request; held high until granted.
- aux_addr  in  ADDR_W  auxiliary read address; sampled on grant.
- aux_gnt  out  1  one-cycle pulse: aux_addr is driven to the ROM this cycle.
- aux_valid  out  1  one-cycle pulse ROM_LAT cycles after aux_gnt.
- aux_data  out  DATA_W  ROM data for the aux read; qualified by aux_valid.
- bg_index  out  DATA_W  palette index for the current (DrawX, DrawY).
- fetch_busy  out  1  high while FSM is in FETCH or DRAIN.
- overrun  out  1  sticky error flag; cleared only by Reset.

Behaviour:
- Reset (async):
  - FSM goes to IDLE; bank select and word counter are cleared.
  - rom_addr=0, aux_gnt=0, aux_valid=0, aux_data=0, bg_index=0, fetch_busy=0, overrun=0.
  - Line-buffer contents are undefined after reset.
- Trigger:
  - The trigger is a one-cycle pulse on the first cycle of DrawX==H_VISIBLE; it is edge-detected, so it fires once per line.
  - Target line: tgt = (DrawY==V_TOTAL-1) ? 0 : DrawY+1.
  - A fetch starts only if tgt < V_VISIBLE.
- FSM states:
  - IDLE: on trigger with a valid tgt, load base=tgt*WORDS_PER_LINE and k=0, then go to FETCH.
  - FETCH: rom_addr=base+k each cycle and k increments. After k=WORDS_PER_LINE-1 is issued, go to DRAIN.
  - DRAIN: wait ROM_LAT cycles for the last data, then go to IDLE and set a pending-swap flag.
- Write path:
  - A ROM_LAT-deep shift register tags each issued read as BG (with its word index) or AUX.
  - BG data is written into the inactive bank at the tagged word index.
- Bank swap:
  - Detected when DrawY changes value (line boundary).
  - If pending-swap is set: toggle the active bank and clear pending-swap.
  - If the FSM is not IDLE at that moment: set overrun; finish the fetch anyway; the swap happens at the next line boundary.
- Pixel output:
  - bg_index is registered: the active-bank word at DrawX>>3, 1-cycle latency.
  - bg_index=0 when DrawX>=H_VISIBLE or DrawY>=V_VISIBLE.
- Arbitration:
  - The BG fetch owns the ROM in FETCH.
  - aux_req is granted only in IDLE or DRAIN, when no BG address issues that cycle.
  - At most one grant per cycle.
  - aux_req coincident with trigger: the trigger wins; aux waits up to WORDS_PER_LINE+1 cycles.
  - Aux reads already in flight when FETCH begins complete normally; tags keep BG and AUX data separate.
  - aux_data holds its last value between aux_valid pulses.
- Widths and timing:
  - base computed in ADDR_W bits; maximum address 479*80+79 = 38399.
  - Blanking is 320 cycles and a fetch takes 80+ROM_LAT cycles, so overrun occurs only on protocol violation.
- Reset mid-FETCH: the FSM aborts immediately, no swap occurs, and the next trigger restarts cleanly.

Test Plan:
- Reset, then drive raster with ROM word value = address[7:0].
  - Line 524 trigger → rom_addr runs 0..79 consecutively.
  - On line 0, bg_index at DrawX=17 equals 2.
- Line 10 trigger fetches line 11 → rom_addr runs 880..959.
  - After the line-11 boundary, bg_index at DrawX=639 equals 959[7:0]=0xBF.
- aux_req high with aux_addr=0x1234 while in FETCH → aux_gnt held off until FETCH ends.
  - aux_gnt asserts within 1 cycle of entering DRAIN; aux_valid follows ROM_LAT cycles later with aux_data=0x34.
  - BG buffer word 79 is uncorrupted.
- Line 479 trigger (tgt=480) → no fetch: fetch_busy stays 0 and aux_req is granted next cycle.
- Force DrawY change 20 cycles after a trigger → overrun=1.
  - The active bank is unchanged on that line and swaps at the following boundary.
- Assert Reset 30 cycles into FETCH → all outputs are 0 the same cycle.
  - The next line-524 trigger produces a full 0..79 address burst.

Source files
------------

// File: rtl/bg_line_prefetcher.sv
// Background line prefetcher: copies the next scanline's ROM words into the idle half
// of a ping-pong line buffer during h-blank and serves per-pixel palette indices.
module bg_line_prefetcher #(
    parameter int H_VISIBLE      = 640,
    parameter int V_VISIBLE      = 480,
    parameter int V_TOTAL        = 525,
    parameter int WORDS_PER_LINE = 80,
    parameter int ROM_LAT        = 1,
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              aux_req,
    input  logic [ADDR_W-1:0] aux_addr,
    output logic              aux_gnt,
    output logic              aux_valid,
    output logic [DATA_W-1:0] aux_data,
    output logic [DATA_W-1:0] bg_index,
    output logic              fetch_busy,
    output logic              overrun
);
    localparam int KW = $clog2(WORDS_PER_LINE);
    localparam int DW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [KW-1:0]     K_LAST = KW'(WORDS_PER_LINE - 1);
    localparam logic [DW-1:0]     D_LAST = DW'(ROM_LAT - 1);
    localparam logic [ADDR_W-1:0] WPL_A  = ADDR_W'(WORDS_PER_LINE);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   base;
    logic [KW-1:0]       k;
    logic [DW-1:0]       drain_cnt;
    logic                bank;
    logic                pending;
    logic                x_hv_q;
    logic [9:0]          y_q;
    logic [DATA_W-1:0]   aux_hold;

    logic [ROM_LAT:0]         tag_bg;
    logic [ROM_LAT:0]         tag_aux;
    logic [ROM_LAT:0][KW-1:0] tag_idx;

    logic [DATA_W-1:0] lbuf [2][WORDS_PER_LINE];

    logic          x_at_hv, trig, tgt_ok, start, bg_issue, aux_issue, line_chg, vis;
    logic [9:0]    tgt;
    logic [KW-1:0] rd_idx;

    assign x_at_hv   = (DrawX == 10'(H_VISIBLE));
    assign trig      = x_at_hv && !x_hv_q;
    assign tgt       = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
    assign tgt_ok    = (tgt < 10'(V_VISIBLE));
    assign start     = (state == IDLE) && trig && tgt_ok;
    assign bg_issue  = (state == FETCH);
    // A trigger that starts a fetch takes precedence over a waiting aux request.
    assign aux_issue = aux_req && ((state == DRAIN) || ((state == IDLE) && !start));
    assign line_chg  = (DrawY != y_q);
    assign vis       = (DrawX < 10'(H_VISIBLE)) && (DrawY < 10'(V_VISIBLE));
    assign rd_idx    = vis ? KW'(DrawX >> 3) : '0;

    assign fetch_busy = (state != IDLE);
    assign aux_valid  = tag_aux[ROM_LAT];
    assign aux_data   = aux_valid ? rom_data : aux_hold;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            base      <= '0;
            k         <= '0;
            drain_cnt <= '0;
            rom_addr  <= '0;
            aux_gnt   <= 1'b0;
            bank      <= 1'b0;
            pending   <= 1'b0;
            overrun   <= 1'b0;
            x_hv_q    <= 1'b0;
            y_q       <= '0;
        end else begin
            x_hv_q  <= x_at_hv;
            y_q     <= DrawY;
            aux_gnt <= aux_issue;
            if (bg_issue)
                rom_addr <= base + ADDR_W'(k);
            else if (aux_issue)
                rom_addr <= aux_addr;

            // Swap only once the new line is completely in the idle bank.
            if (line_chg) begin
                if (state != IDLE)
                    overrun <= 1'b1;
                else if (pending) begin
                    bank    <= ~bank;
                    pending <= 1'b0;
                end
            end

            unique case (state)
                IDLE: if (start) begin
                    base  <= ADDR_W'(tgt) * WPL_A;
                    k     <= '0;
                    state <= FETCH;
                end
                FETCH: begin
                    k <= k + 1'b1;
                    if (k == K_LAST) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == D_LAST) begin
                        state   <= IDLE;
                        pending <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 0 describes the address now on rom_addr; stage ROM_LAT lines up with rom_data.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tag_bg  <= '0;
            tag_aux <= '0;
            tag_idx <= '0;
        end else begin
            tag_bg  <= {tag_bg[ROM_LAT-1:0], bg_issue};
            tag_aux <= {tag_aux[ROM_LAT-1:0], aux_issue};
            tag_idx <= {tag_idx[ROM_LAT-1:0], k};
        end
    end

    always_ff @(posedge Clk) begin
        if (tag_bg[ROM_LAT])
            lbuf[~bank][tag_idx[ROM_LAT]] <= rom_data;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bg_index <= '0;
            aux_hold <= '0;
        end else begin
            bg_index <= vis ? lbuf[bank][rd_idx] : '0;
            if (aux_valid)
                aux_hold <= rom_data;
        end
    end
endmodule

// File: tb/tb_bg_line_prefetcher.sv
// Directed bench for bg_line_prefetcher with a line/transaction-level reference model
// and a synchronous ROM whose word value is address[7:0].
module tb_bg_line_prefetcher;
    localparam int WPL = 80;
    localparam int LAT = 1;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX, DrawY;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        aux_req;
    logic [15:0] aux_addr;
    logic        aux_gnt, aux_valid;
    logic [7:0]  aux_data, bg_index;
    logic        fetch_busy, overrun;

    int n_cmp = 0;
    int n_bad = 0;

    bg_line_prefetcher dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .aux_req(aux_req), .aux_addr(aux_addr), .aux_gnt(aux_gnt),
        .aux_valid(aux_valid), .aux_data(aux_data),
        .bg_index(bg_index), .fetch_busy(fetch_busy), .overrun(overrun)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) rom_data <= rom_addr[7:0];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a fetch occupies WPL issue cycles plus LAT drain cycles after
    // its trigger; the finished line lands in the idle bank and becomes visible at
    // the next line change that finds no fetch in progress.
    int  m_cnt = 0, m_base = 0, m_tgt = 0, m_addr = 0, m_adata = 0, m_vaddr = 0;
    int  m_bg = 0, m_px = 0, m_py = 0;
    int  m_line [2];
    bit  m_known [2];
    bit  m_act = 0, m_pend = 0, m_gnt = 0, m_vld = 0, m_vnext = 0, m_ovr = 0, m_bgchk = 0;

    always @(posedge Clk or posedge Reset) begin : model
        bit busy_pre, issue, trig, start;
        int tgt;
        if (Reset) begin
            m_cnt = 0; m_addr = 0; m_adata = 0; m_bg = 0; m_px = 0; m_py = 0;
            m_act = 0; m_pend = 0; m_gnt = 0; m_vld = 0; m_vnext = 0; m_ovr = 0;
            m_bgchk = 0; m_known[0] = 0; m_known[1] = 0;
        end else begin
            busy_pre = (m_cnt > 0);
            issue    = (m_cnt > LAT);
            trig     = (DrawX == 640) && (m_px != 640);
            tgt      = (DrawY == 524) ? 0 : int'(DrawY) + 1;
            start    = !busy_pre && trig && (tgt < 480);

            if (DrawX < 640 && DrawY < 480) begin
                m_bgchk = m_known[m_act];
                m_bg    = (m_line[m_act] * WPL + int'(DrawX) / 8) % 256;
            end else begin
                m_bgchk = 1;
                m_bg    = 0;
            end

            m_vld = m_vnext;
            if (m_vnext) m_adata = m_vaddr % 256;
            m_gnt = 0; m_vnext = 0;
            if (issue)
                m_addr = m_base + (WPL + LAT - m_cnt);
            else if (aux_req && !start) begin
                m_addr = int'(aux_addr); m_gnt = 1; m_vnext = 1; m_vaddr = int'(aux_addr);
            end

            if (int'(DrawY) != m_py) begin
                if (busy_pre) m_ovr = 1;
                else if (m_pend) begin m_act = !m_act; m_pend = 0; end
            end

            if (busy_pre) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_pend = 1;
                    m_line[m_act ? 0 : 1]  = m_tgt;
                    m_known[m_act ? 0 : 1] = 1;
                end
            end else if (start) begin
                m_cnt = WPL + LAT; m_base = tgt * WPL; m_tgt = tgt;
            end
            m_px = int'(DrawX);
            m_py = int'(DrawY);
        end
    end

    always @(negedge Clk) begin
        if (!Reset) begin
            cmp("rom_addr",   rom_addr,   m_addr);
            cmp("aux_gnt",    aux_gnt,    m_gnt);
            cmp("aux_valid",  aux_valid,  m_vld);
            cmp("aux_data",   aux_data,   m_adata);
            cmp("fetch_busy", fetch_busy, m_cnt > 0);
            cmp("overrun",    overrun,    m_ovr);
            if (m_bgchk) cmp("bg_index", bg_index, m_bg);
        end
    end

    // Burst recorder: first/last BG address of the most recent fetch and how many steps were +1.
    int b_first = -1, b_last = -1, b_inc = 0;
    bit busy_d = 0, busy_d2 = 0;
    always @(negedge Clk) begin
        if (busy_d && !busy_d2) begin
            b_first = int'(rom_addr); b_last = int'(rom_addr); b_inc = 0;
        end else if (busy_d && fetch_busy) begin
            if (int'(rom_addr) == b_last + 1) b_inc++;
            b_last = int'(rom_addr);
        end
        busy_d2 = busy_d;
        busy_d  = fetch_busy;
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge Clk); #1; end
    endtask

    task automatic hold(input int y, input int x);
        DrawY = 10'(y); DrawX = 10'(x);
        cyc(2);
    endtask

    task automatic run(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) hold(y, x);
    endtask

    task automatic chk_burst(input string nm, input int first, input int last);
        cmp({nm, "_first"}, b_first, first);
        cmp({nm, "_last"},  b_last,  last);
        cmp({nm, "_steps"}, b_inc,   WPL - 1);
    endtask

    task automatic chk_zero_outputs(input string nm);
        cmp({nm, "_rom_addr"},   rom_addr,   0);
        cmp({nm, "_aux_gnt"},    aux_gnt,    0);
        cmp({nm, "_aux_valid"},  aux_valid,  0);
        cmp({nm, "_aux_data"},   aux_data,   0);
        cmp({nm, "_bg_index"},   bg_index,   0);
        cmp({nm, "_fetch_busy"}, fetch_busy, 0);
        cmp({nm, "_overrun"},    overrun,    0);
    endtask

    initial begin
        int w;
        Reset = 1'b1; DrawX = '0; DrawY = '0; aux_req = 1'b0; aux_addr = '0;
        cyc(3);
        chk_zero_outputs("reset");
        DrawY = 10'd524; DrawX = 10'd630; Reset = 1'b0;

        // Frame wrap: line 524 prefetches line 0
        run(524, 630, 700);
        chk_burst("burst_l0", 0, 79);
        run(0, 0, 16);
        hold(0, 17);
        cmp("bg_l0_x17", bg_index, 8'd2);

        // Line 10 prefetches line 11
        run(10, 636, 700);
        chk_burst("burst_l11", 880, 959);
        hold(11, 639);
        cmp("bg_l11_x639", bg_index, 8'hBF);
        hold(11, 640);
        cmp("bg_hblank", bg_index, 8'd0);
        run(11, 641, 700);

        // Aux request raised mid-FETCH waits for DRAIN
        hold(20, 639);
        hold(20, 640);
        aux_req = 1'b1; aux_addr = 16'h1234;
        w = 0;
        do begin cyc(1); w++; end while (!aux_gnt && w < 200);
        aux_req = 1'b0;
        cmp("aux_wait_fetch", w, 80);
        cyc(1);
        cmp("aux_valid_1234", aux_valid, 1'b1);
        cmp("aux_data_1234", aux_data, 8'h34);
        cyc(1);
        cmp("aux_data_hold", aux_data, 8'h34);
        hold(21, 639);
        cmp("bg_l21_word79", bg_index, 8'hDF);

        // Aux coincident with a valid trigger: trigger wins
        hold(30, 639);
        DrawX = 10'd640; aux_req = 1'b1; aux_addr = 16'h0777;
        w = 0;
        do begin cyc(1); w++; end while (!aux_gnt && w < 200);
        aux_req = 1'b0;
        cmp("aux_wait_trig", w, 82);
        cyc(1);
        cmp("aux_data_0777", aux_data, 8'h77);

        // Line 479 trigger targets 480: no fetch, aux granted at once
        hold(479, 639);
        DrawX = 10'd640; aux_req = 1'b1; aux_addr = 16'h0456;
        cyc(1);
        cmp("aux_gnt_l479", aux_gnt, 1'b1);
        cmp("busy_l479", fetch_busy, 1'b0);
        aux_req = 1'b0;
        cyc(1);
        cmp("aux_data_0456", aux_data, 8'h56);
        cyc(3);
        cmp("busy_l479_late", fetch_busy, 1'b0);

        // Line change 20 cycles into a fetch
        hold(40, 639);
        DrawX = 10'd640;
        cyc(20);
        DrawY = 10'd41;
        cyc(1);
        cmp("overrun_set", overrun, 1'b1);
        cyc(70);
        hold(41, 0);
        cmp("bg_l41_old_bank", bg_index, 8'hB0);
        hold(42, 0);
        cmp("bg_l42_swapped", bg_index, 8'hD0);
        cmp("overrun_sticky", overrun, 1'b1);

        // Reset 30 cycles into FETCH
        hold(50, 639);
        DrawX = 10'd640;
        cyc(31);
        Reset = 1'b1;
        #1;
        chk_zero_outputs("midreset");
        cyc(2);
        DrawY = 10'd524; DrawX = 10'd630; Reset = 1'b0;
        run(524, 630, 700);
        chk_burst("burst_after_reset", 0, 79);
        run(0, 0, 16);
        hold(0, 17);
        cmp("bg_l0_after_reset", bg_index, 8'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
